// File: rtl/vga_pkg.sv
// Shared types and reset timing for the raster timing generator.
package vga_pkg;
   localparam int COORD_W = 11;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t act;
      coord_t fp;
      coord_t sync;
      coord_t bp;
   } timing_cfg_t;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} vga_state_e;

   // Raster flags carried alongside the read latency; sync bits are "asserted", not levels.
   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic       fs;
      logic       fe;
      logic [1:0] pol;
   } tim_bits_t;

   localparam int H_ACT_D = 640;
   localparam int H_FP_D  = 16;
   localparam int H_SY_D  = 96;
   localparam int H_BP_D  = 48;
   localparam int V_ACT_D = 480;
   localparam int V_FP_D  = 10;
   localparam int V_SY_D  = 2;
   localparam int V_BP_D  = 33;

   function automatic coord_t cfg_total(input timing_cfg_t c);
      return c.act + c.fp + c.sync + c.bp;
   endfunction
endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: counter with wrap, visible window and sync window decode.
module vga_axis_timer
   import vga_pkg::*;
(
   input  logic        clk,
   input  logic        srst,
   input  logic        clr,
   input  logic        adv,
   input  timing_cfg_t cfg,
   output coord_t      cnt,
   output logic        last,
   output logic        vis,
   output logic        sync
);
   coord_t sync_lo, sync_hi;

   always_comb begin
      sync_lo = cfg.act + cfg.fp;
      sync_hi = sync_lo + cfg.sync;
   end

   assign last = (cnt == cfg_total(cfg) - coord_t'(1));
   assign vis  = (cnt < cfg.act);
   assign sync = (cnt >= sync_lo) && (cnt < sync_hi);

   always_ff @(posedge clk or posedge srst)
      if (srst)     cnt <= '0;
      else if (clr) cnt <= '0;
      else if (adv) cnt <= last ? '0 : cnt + coord_t'(1);
endmodule

// File: rtl/vga_timing_gen.sv
// Configurable raster generator: H/V counters, VRAM pixel fetch, latency-matched syncs/DE/RGB,
// and tear-free shadow configuration committed at the frame boundary.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int RGB_W    = 12,
   parameter int ADDR_W   = 20,
   parameter int READ_LAT = 2,
   parameter int H_ACT    = H_ACT_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SY     = H_SY_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACT    = V_ACT_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SY     = V_SY_D,
   parameter int V_BP     = V_BP_D
)(
   input  logic                 clk,
   input  logic                 srst,
   input  logic                 enable,
   input  logic [4*COORD_W-1:0] cfg_h,
   input  logic [4*COORD_W-1:0] cfg_v,
   input  logic [ADDR_W-1:0]    cfg_stride,
   input  logic [1:0]           cfg_pol,
   input  logic                 cfg_load,
   output logic                 cfg_busy,
   input  logic [RGB_W-1:0]     clear,
   output logic                 req_valid,
   output logic [ADDR_W-1:0]    req_addr,
   input  logic [RGB_W-1:0]     pix_data,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 de,
   output logic [RGB_W-1:0]     rgb,
   output logic                 frame_start,
   output logic                 frame_end
);
   localparam timing_cfg_t H_RST = '{act: coord_t'(H_ACT), fp: coord_t'(H_FP), sync: coord_t'(H_SY), bp: coord_t'(H_BP)};
   localparam timing_cfg_t V_RST = '{act: coord_t'(V_ACT), fp: coord_t'(V_FP), sync: coord_t'(V_SY), bp: coord_t'(V_BP)};

   timing_cfg_t       act_h, act_v, pnd_h, pnd_v;
   logic [ADDR_W-1:0] act_stride, pnd_stride, line_base;
   logic [1:0]        act_pol, pnd_pol;
   vga_state_e        state;
   logic [2:0]        dcnt;
   logic              run, commit, pnd_ok;
   coord_t            h_cnt, v_cnt;
   logic              h_last, v_last, h_vis, v_vis, h_sy, v_sy;
   tim_bits_t         tim_s0, tim_d;

   assign run    = (state == RUN);
   assign pnd_ok = (pnd_h.act != '0) && (pnd_v.act != '0) &&
                   (cfg_total(pnd_h) != '0) && (cfg_total(pnd_v) != '0);
   assign commit = cfg_busy && ((state == IDLE) || (run && h_last && v_last));

   // A load landing on the commit cycle re-arms busy for the next boundary.
   always_ff @(posedge clk or posedge srst)
      if (srst) begin
         act_h      <= H_RST;
         act_v      <= V_RST;
         act_stride <= ADDR_W'(H_ACT);
         act_pol    <= 2'b00;
         pnd_h      <= H_RST;
         pnd_v      <= V_RST;
         pnd_stride <= ADDR_W'(H_ACT);
         pnd_pol    <= 2'b00;
         cfg_busy   <= 1'b0;
      end else begin
         if (commit && pnd_ok) begin
            act_h      <= pnd_h;
            act_v      <= pnd_v;
            act_stride <= pnd_stride;
            act_pol    <= pnd_pol;
         end
         if (cfg_load) begin
            pnd_h      <= timing_cfg_t'(cfg_h);
            pnd_v      <= timing_cfg_t'(cfg_v);
            pnd_stride <= cfg_stride;
            pnd_pol    <= cfg_pol;
         end
         if (cfg_load)    cfg_busy <= 1'b1;
         else if (commit) cfg_busy <= 1'b0;
      end

   always_ff @(posedge clk or posedge srst)
      if (srst) begin
         state <= IDLE;
         dcnt  <= '0;
      end else begin
         case (state)
            IDLE:    if (enable) state <= RUN;
            RUN:     if (!enable) begin
                        state <= (READ_LAT == 0) ? IDLE : DRAIN;
                        dcnt  <= '0;
                     end
            DRAIN:   if (dcnt == 3'(READ_LAT - 1)) state <= IDLE;
                     else                          dcnt  <= dcnt + 3'd1;
            default: state <= IDLE;
         endcase
      end

   vga_axis_timer u_h (.clk, .srst, .clr(!run), .adv(run), .cfg(act_h),
                       .cnt(h_cnt), .last(h_last), .vis(h_vis), .sync(h_sy));
   vga_axis_timer u_v (.clk, .srst, .clr(!run), .adv(run && h_last), .cfg(act_v),
                       .cnt(v_cnt), .last(v_last), .vis(v_vis), .sync(v_sy));

   always_ff @(posedge clk or posedge srst)
      if (srst)                             line_base <= '0;
      else if (!run || (h_last && v_last))  line_base <= '0;
      else if (h_last && v_vis)             line_base <= line_base + act_stride;

   assign req_valid = run && h_vis && v_vis;
   assign req_addr  = line_base + ADDR_W'(h_cnt);

   always_comb begin
      tim_s0     = '0;
      tim_s0.pol = act_pol;
      if (run) begin
         tim_s0.hs = h_sy;
         tim_s0.vs = v_sy;
         tim_s0.de = h_vis && v_vis;
         tim_s0.fs = h_vis && v_vis && (h_cnt == '0) && (v_cnt == '0);
         tim_s0.fe = h_vis && v_vis && (h_cnt == act_h.act - coord_t'(1)) &&
                     (v_cnt == act_v.act - coord_t'(1));
      end
   end

   // Polarity travels with each entry so a mode change never retimes in-flight syncs.
   generate
      if (READ_LAT == 0) begin : g_nolat
         assign tim_d = tim_s0;
      end else begin : g_lat
         tim_bits_t tim_pipe [READ_LAT:1];
         always_ff @(posedge clk or posedge srst)
            if (srst) begin
               for (int i = 1; i <= READ_LAT; i++) tim_pipe[i] <= '0;
            end else begin
               tim_pipe[1] <= tim_s0;
               for (int i = 2; i <= READ_LAT; i++) tim_pipe[i] <= tim_pipe[i-1];
            end
         assign tim_d = tim_pipe[READ_LAT];
      end
   endgenerate

   always_ff @(posedge clk or posedge srst)
      if (srst) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         de          <= 1'b0;
         rgb         <= '0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
      end else begin
         hsync       <= tim_d.hs ~^ tim_d.pol[0];
         vsync       <= tim_d.vs ~^ tim_d.pol[1];
         de          <= tim_d.de;
         rgb         <= tim_d.de ? pix_data : ((state == IDLE) ? clear : '0);
         frame_start <= tim_d.fs;
         frame_end   <= tim_d.fe;
      end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen: VRAM echoes the request address two clocks later.
module tb_vga_timing_gen;
   import vga_pkg::*;

   localparam int RGB_W  = 12;
   localparam int ADDR_W = 20;
   localparam int LIMIT  = 2000;
   localparam logic [RGB_W-1:0] CLR = 12'h5A5;
   localparam logic [RGB_W-1:0] SMALL_PX [0:11] = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd8, 12'd9,
                                                    12'd10, 12'd11, 12'd16, 12'd17, 12'd18, 12'd19};
   localparam logic [RGB_W-1:0] NEW_PX [0:3] = '{12'd0, 12'd1, 12'd4, 12'd5};

   logic                 clk = 1'b0;
   logic                 srst, enable, cfg_load, cfg_busy, req_valid;
   logic                 hsync, vsync, de, frame_start, frame_end;
   logic [4*COORD_W-1:0] cfg_h, cfg_v;
   logic [ADDR_W-1:0]    cfg_stride, req_addr;
   logic [1:0]           cfg_pol;
   logic [RGB_W-1:0]     clear, pix_data, rgb;
   logic [RGB_W-1:0]     vr1 = '0, vr2 = '0;

   typedef struct packed {
      logic [RGB_W-1:0] rgb;
      logic             fs;
      logic             fe;
   } exp_t;

   exp_t sbq [$];
   exp_t mon_e;
   int   checks = 0, errors = 0;
   bit   sb_on = 1'b0;

   vga_timing_gen dut (
      .clk, .srst, .enable, .cfg_h, .cfg_v, .cfg_stride, .cfg_pol, .cfg_load, .cfg_busy,
      .clear, .req_valid, .req_addr, .pix_data, .hsync, .vsync, .de, .rgb,
      .frame_start, .frame_end
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      vr1 <= req_valid ? req_addr[RGB_W-1:0] : 12'hBAD;
      vr2 <= vr1;
   end
   assign pix_data = vr2;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (sb_on) begin
         if (de) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_de: got rgb %0h with no expected pixel queued", rgb);
            end else begin
               mon_e = sbq.pop_front();
               chk("sb_rgb", 32'(rgb), 32'(mon_e.rgb));
               chk("sb_frame_start", 32'(frame_start), 32'(mon_e.fs));
               chk("sb_frame_end", 32'(frame_end), 32'(mon_e.fe));
            end
         end else if (frame_start || frame_end) begin
            checks++;
            errors++;
            $display("FAIL sb_marker_without_de: got fs=%0b fe=%0b want 0 0", frame_start, frame_end);
         end
      end
   end

   task automatic push_small(input int n);
      for (int i = 0; i < n; i++)
         sbq.push_back(exp_t'{rgb: SMALL_PX[i], fs: (i == 0), fe: (i == 11)});
   endtask

   task automatic push_new();
      for (int i = 0; i < 4; i++)
         sbq.push_back(exp_t'{rgb: NEW_PX[i], fs: (i == 0), fe: (i == 3)});
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout want event within %0d cycles", name, LIMIT);
   endtask

   task automatic wait_fs(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!frame_start && n < LIMIT);
      if (!frame_start) timeout("wait_frame_start");
   endtask

   task automatic wait_fe();
      int n = 0;
      do begin @(negedge clk); n++; end while (!frame_end && n < LIMIT);
      if (!frame_end) timeout("wait_frame_end");
   endtask

   task automatic wait_addr(input logic [ADDR_W-1:0] a);
      int n = 0;
      do begin @(negedge clk); n++; end while (!(req_valid && req_addr == a) && n < LIMIT);
      if (!(req_valid && req_addr == a)) timeout("wait_req_addr");
   endtask

   task automatic load_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, input int stride,
                           input logic [1:0] pol);
      cfg_h      = {COORD_W'(ha), COORD_W'(hf), COORD_W'(hs), COORD_W'(hb)};
      cfg_v      = {COORD_W'(va), COORD_W'(vf), COORD_W'(vs), COORD_W'(vb)};
      cfg_stride = ADDR_W'(stride);
      cfg_pol    = pol;
      cfg_load   = 1'b1;
      @(negedge clk);
      cfg_load   = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish want finish before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, hs_hi, vs_hi;
      srst = 1'b1; enable = 1'b0; cfg_load = 1'b0; clear = CLR;
      cfg_h = '0; cfg_v = '0; cfg_stride = '0; cfg_pol = 2'b00;
      repeat (3) @(negedge clk);
      chk("rst_hsync", 32'(hsync), 1);
      chk("rst_vsync", 32'(vsync), 1);
      chk("rst_de", 32'(de), 0);
      chk("rst_rgb", 32'(rgb), 0);
      chk("rst_req_valid", 32'(req_valid), 0);
      chk("rst_req_addr", 32'(req_addr), 0);
      chk("rst_cfg_busy", 32'(cfg_busy), 0);
      chk("rst_frame_start", 32'(frame_start), 0);
      chk("rst_frame_end", 32'(frame_end), 0);
      srst = 1'b0;
      @(negedge clk);
      chk("idle_rgb_clear", 32'(rgb), 32'(CLR));

      // Default 640x480 timing, horizontal checks.
      enable = 1'b1;
      wait_fs(n);
      chk("def_first_pixel", 32'(rgb), 0);
      n = 0;
      while (hsync && n < LIMIT) begin @(negedge clk); n++; end
      chk("def_hsync_start", n, 656);
      n = 0;
      while (!hsync && n < LIMIT) begin @(negedge clk); n++; end
      chk("def_hsync_width", n, 96);
      n = 0;
      while (hsync && n < LIMIT) begin @(negedge clk); n++; end
      chk("def_hsync_gap", n, 704);
      chk("def_vsync_idle", 32'(vsync), 1);
      enable = 1'b0;
      repeat (6) @(negedge clk);
      chk("def_drained_de", 32'(de), 0);

      // Small mode loaded while idle commits immediately.
      load_cfg(4, 1, 2, 1, 3, 1, 1, 1, 8, 2'b00);
      chk("idle_load_busy", 32'(cfg_busy), 1);
      @(negedge clk);
      chk("idle_commit_busy", 32'(cfg_busy), 0);
      push_small(12); push_small(12); push_small(3);
      sb_on  = 1'b1;
      enable = 1'b1;
      wait_fs(n);
      wait_fs(n);
      chk("small_frame_len", n, 48);
      wait_addr(0);
      wait_addr(2);
      enable = 1'b0;
      @(negedge clk);
      chk("drain_req_valid", 32'(req_valid), 0);
      repeat (3) @(negedge clk);
      chk("drain_de", 32'(de), 0);
      chk("drain_rgb_clear", 32'(rgb), 32'(CLR));
      chk("drain_hsync", 32'(hsync), 1);

      // Restart, then shadow commit mid-frame.
      push_small(12);
      repeat (6) push_new();
      enable = 1'b1;
      wait_fs(n);
      repeat (10) @(negedge clk);
      load_cfg(2, 1, 1, 1, 2, 1, 1, 1, 4, 2'b00);
      chk("shadow_busy_set", 32'(cfg_busy), 1);
      repeat (5) @(negedge clk);
      chk("shadow_busy_hold", 32'(cfg_busy), 1);
      wait_fs(n);
      chk("shadow_busy_clear", 32'(cfg_busy), 0);
      wait_fs(n);
      chk("new_frame_len", n, 25);

      // Active-high syncs.
      load_cfg(2, 1, 1, 1, 2, 1, 1, 1, 4, 2'b11);
      wait_fs(n);
      chk("pol_hsync_inactive", 32'(hsync), 0);
      chk("pol_vsync_inactive", 32'(vsync), 0);
      n = 0; hs_hi = 0; vs_hi = 0;
      do begin
         @(negedge clk); n++;
         hs_hi += int'(hsync);
         vs_hi += int'(vsync);
      end while (!frame_start && n < LIMIT);
      chk("pol_hsync_high", hs_hi, 5);
      chk("pol_vsync_high", vs_hi, 5);

      // Zero active width is rejected at commit.
      load_cfg(0, 1, 1, 1, 2, 1, 1, 1, 4, 2'b11);
      chk("reject_busy_set", 32'(cfg_busy), 1);
      wait_fs(n);
      chk("reject_busy_clear", 32'(cfg_busy), 0);
      wait_fs(n);
      chk("reject_frame_len", n, 25);
      wait_fe();
      enable = 1'b0;
      repeat (6) @(negedge clk);
      chk("sb_left", sbq.size(), 0);
      chk("end_de", 32'(de), 0);
      chk("end_rgb_clear", 32'(rgb), 32'(CLR));
      chk("end_hsync_pos", 32'(hsync), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
